dest_route_lookup: RTL and testbench
====================================

# dest_route_lookup

Destination routing table store and lookup engine, directly downstream of the unified table reader. Captures the 256-bit entries that the reader streams out during initialisation. Once the reader signals completion, it serves dst_ip lookup requests from the packet path with a first-match linear scan. Each lookup returns the forwarding fields of the matching entry, or a miss.

## Interface
- MAX_ENTRIES, 64: table depth; entry address width is clog2(MAX_ENTRIES).
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- init_data  in  256  entry from the table reader.
- init_addr  in  6  entry index.
- init_valid  in  1  one-cycle write strobe.
- init_done  in  1  level signal from the reader: load complete.
- init_error  in  1  level signal from the reader: load failed.
- req_valid / req_ready  in / out  1 / 1  lookup request handshake.
- req_dst_ip  in  32  destination IP to look up.
- resp_valid / resp_ready  out / in  1 / 1  response handshake.
- resp_hit  out  1  a matching entry was found.
- resp_broadcast, resp_direct_host  out  1 each  flags from the matched entry.
- resp_out_port, resp_out_qp  out  16 each.
- resp_next_hop_ip  out  32.
- resp_next_hop_port, resp_next_hop_qp  out  16 each.
- resp_next_hop_mac  out  48.
- table_ready  out  1  load finished successfully.
- table_error  out  1  load failed.
- entry_count  out  7  highest written index + 1.

## Operation
- Entry bit map:
  - dst_ip = [31:0]
  - valid = [32], is_direct_host = [33], is_broadcast = [34]
  - out_port = [79:64], out_qp = [95:80]
  - next_hop_ip = [127:96]
  - next_hop_port = [143:128], next_hop_qp = [159:144]
  - next_hop_mac = {[207:192], [175:160], [191:176]}, i.e. mac[47:32], mac[31:16], mac[15:0]
- FSM states: LOAD, IDLE, SEARCH, RESP, ERROR. Reset enters LOAD.
- LOAD:
  - Each init_valid writes init_data to entry[init_addr].
  - entry_count becomes max(entry_count, init_addr+1).
  - A repeated address overwrites the entry without changing the count.
  - init_error takes priority over init_done: init_error → ERROR; init_done → IDLE.
- init_valid outside LOAD is ignored. Reloading the table requires rst.
- IDLE: req_ready=1. On req_valid, latch req_dst_ip, set idx=0, go to SEARCH.
- SEARCH: one entry per cycle.
  - idx ≥ entry_count → miss, go to RESP.
  - entry[idx].valid && entry[idx].dst_ip == key → hit, latch fields, go to RESP.
  - Otherwise idx++.
  - The lowest matching index wins. Entries with valid=0 never match.
- RESP: resp_valid=1, fields held stable. On resp_ready → IDLE.
- On a miss, resp_hit=0 and every resp field is 0.
- ERROR: table_error=1 and req_ready=0 permanently until rst.

## Timing
- Reset values:
  - state=LOAD, entry_count=0, table_ready=0, table_error=0
  - req_ready=0, resp_valid=0, resp_hit=0, all resp fields 0
- Entry storage contents are not reset.
- A request is accepted in cycle T (req_valid && req_ready).
  - Hit at index k: resp_valid rises in cycle T+2+k.
  - Miss: resp_valid rises in cycle T+2+entry_count. With entry_count=0 this is T+2.
- req_ready falls the cycle after acceptance. It returns the cycle after resp handshake. No request overlap, throughput is one lookup in flight.
- resp_ready held high in RESP: resp_valid is high for exactly one cycle. IDLE is always at least one cycle.
- table_ready rises in the cycle after init_done is sampled. An init_valid in the same cycle as init_done is still written.
- rst mid-SEARCH or mid-RESP: the response is dropped and the block returns to LOAD. Table contents become don't-care.

## Structure
- Shared package route_pkg holds:
  - the entry field offset constants
  - the FSM state encoding
  - the DEST magic value 32'h44455354, shared with the reader
- Sub-module route_entry_ram: MAX_ENTRIES×256 register array, one synchronous write port, one asynchronous read port addressed by idx.

## Test plan
- Load 3 entries: idx0 dst_ip 10.0.0.1, idx1 10.0.0.2, idx2 10.0.0.3, all valid. Then init_done. Look up 10.0.0.2 → hit at T+3, out_port/next_hop fields equal those written at idx1, entry_count=3.
- Look up 10.0.0.9 on the same table → resp_hit=0, all fields 0, resp_valid at T+5.
- Two entries with the same dst_ip: idx1 out_port 5, idx3 out_port 9 → response has out_port 5.
- Entry with valid=0 and dst_ip=10.0.0.7 → lookup misses.
- Hold resp_ready=0 for 10 cycles → resp stays stable and req_ready stays 0. Raise resp_ready → req_ready is 1 in the next cycle.
- Assert init_error with init_done → table_error=1 and req_ready stays 0. Then rst → LOAD, with entry_count=0.
- init_done with no entries written → any lookup misses at T+2.

Source files
------------

// File: rtl/route_pkg.sv
// ============================================================================
// Module      : route_pkg
// Description : Shared constants, FSM encoding and field types for the
//               destination routing table store and lookup engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package route_pkg;

  localparam int ENTRY_W         = 256;

  // Entry bit positions, as produced by the table reader
  localparam int DST_IP_LSB      = 0;
  localparam int VALID_BIT       = 32;
  localparam int DIRECT_HOST_BIT = 33;
  localparam int BROADCAST_BIT   = 34;
  localparam int OUT_PORT_LSB    = 64;
  localparam int OUT_QP_LSB      = 80;
  localparam int NH_IP_LSB       = 96;
  localparam int NH_PORT_LSB     = 128;
  localparam int NH_QP_LSB       = 144;
  localparam int MAC_MID_LSB     = 160;
  localparam int MAC_LO_LSB      = 176;
  localparam int MAC_HI_LSB      = 192;

  localparam logic [31:0] DEST_MAGIC = 32'h4445_5354;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_SEARCH = 3'd2,
    ST_RESP   = 3'd3,
    ST_ERROR  = 3'd4
  } route_state_e;

  typedef struct packed {
    logic        broadcast;
    logic        direct_host;
    logic [15:0] out_port;
    logic [15:0] out_qp;
    logic [31:0] next_hop_ip;
    logic [15:0] next_hop_port;
    logic [15:0] next_hop_qp;
    logic [47:0] next_hop_mac;
  } route_fields_t;

  function automatic logic entry_matches(input logic valid, input logic [31:0] dst_ip,
                                         input logic [31:0] key);
    return valid && (dst_ip == key);
  endfunction

endpackage

`default_nettype wire

// File: rtl/route_entry_ram.sv
// ============================================================================
// Module      : route_entry_ram
// Description : Routing entry register array, one synchronous write port and
//               one asynchronous read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module route_entry_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 256
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // Contents are intentionally not reset; the load phase defines them.
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/dest_route_lookup.sv
// ============================================================================
// Module      : dest_route_lookup
// Description : Captures routing entries during initialisation, then serves
//               dst_ip lookups with a first-match linear scan.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dest_route_lookup #(
  parameter int MAX_ENTRIES = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [255:0]                   init_data,
  input  logic [$clog2(MAX_ENTRIES)-1:0] init_addr,
  input  logic                           init_valid,
  input  logic                           init_done,
  input  logic                           init_error,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_dst_ip,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic                           resp_hit,
  output logic                           resp_broadcast,
  output logic                           resp_direct_host,
  output logic [15:0]                    resp_out_port,
  output logic [15:0]                    resp_out_qp,
  output logic [31:0]                    resp_next_hop_ip,
  output logic [15:0]                    resp_next_hop_port,
  output logic [15:0]                    resp_next_hop_qp,
  output logic [47:0]                    resp_next_hop_mac,
  output logic                           table_ready,
  output logic                           table_error,
  output logic [$clog2(MAX_ENTRIES):0]   entry_count
);
  import route_pkg::*;

  localparam int AW = $clog2(MAX_ENTRIES);
  localparam int CW = AW + 1;

  route_state_e  state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [31:0]   key_q, key_d;
  logic          table_ready_q, table_ready_d;
  logic          hit_q, hit_d;
  route_fields_t fields_q, fields_d;

  logic [ENTRY_W-1:0] rd_data;
  route_fields_t      rd_fields;
  logic               rd_match;
  logic [CW-1:0]      addr_plus1;
  logic               ram_we;
  logic               unused_rd;

  assign ram_we = (state_q == ST_LOAD) && init_valid;

  route_entry_ram #(
    .DEPTH (MAX_ENTRIES),
    .AW    (AW),
    .DW    (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (init_addr),
    .wdata (init_data),
    .raddr (idx_q[AW-1:0]),
    .rdata (rd_data)
  );

  assign rd_fields.broadcast     = rd_data[BROADCAST_BIT];
  assign rd_fields.direct_host   = rd_data[DIRECT_HOST_BIT];
  assign rd_fields.out_port      = rd_data[OUT_PORT_LSB +: 16];
  assign rd_fields.out_qp        = rd_data[OUT_QP_LSB +: 16];
  assign rd_fields.next_hop_ip   = rd_data[NH_IP_LSB +: 32];
  assign rd_fields.next_hop_port = rd_data[NH_PORT_LSB +: 16];
  assign rd_fields.next_hop_qp   = rd_data[NH_QP_LSB +: 16];
  assign rd_fields.next_hop_mac  = {rd_data[MAC_HI_LSB +: 16], rd_data[MAC_MID_LSB +: 16],
                                    rd_data[MAC_LO_LSB +: 16]};

  assign rd_match  = entry_matches(rd_data[VALID_BIT], rd_data[DST_IP_LSB +: 32], key_q);
  assign unused_rd = ^{rd_data[OUT_PORT_LSB-1:BROADCAST_BIT+1], rd_data[ENTRY_W-1:MAC_HI_LSB+16]};

  assign addr_plus1 = {1'b0, init_addr} + CW'(1);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    idx_d         = idx_q;
    key_d         = key_q;
    table_ready_d = table_ready_q;
    hit_d         = hit_q;
    fields_d      = fields_q;

    case (state_q)
      ST_LOAD: begin
        if (init_valid && (addr_plus1 > count_q)) begin
          count_d = addr_plus1;
        end
        if (init_error) begin
          state_d = ST_ERROR;
        end else if (init_done) begin
          state_d       = ST_IDLE;
          table_ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          // Clearing here makes a miss report all-zero fields for free.
          key_d    = req_dst_ip;
          idx_d    = '0;
          hit_d    = 1'b0;
          fields_d = '0;
          state_d  = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (idx_q >= count_q) begin
          state_d = ST_RESP;
        end else if (rd_match) begin
          hit_d    = 1'b1;
          fields_d = rd_fields;
          state_d  = ST_RESP;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      count_q       <= '0;
      idx_q         <= '0;
      key_q         <= '0;
      table_ready_q <= 1'b0;
      hit_q         <= 1'b0;
      fields_q      <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      idx_q         <= idx_d;
      key_q         <= key_d;
      table_ready_q <= table_ready_d;
      hit_q         <= hit_d;
      fields_q      <= fields_d;
    end
  end

  assign req_ready          = (state_q == ST_IDLE);
  assign resp_valid         = (state_q == ST_RESP);
  assign table_error        = (state_q == ST_ERROR);
  assign table_ready        = table_ready_q;
  assign entry_count        = count_q;
  assign resp_hit           = hit_q;
  assign resp_broadcast     = fields_q.broadcast;
  assign resp_direct_host   = fields_q.direct_host;
  assign resp_out_port      = fields_q.out_port;
  assign resp_out_qp        = fields_q.out_qp;
  assign resp_next_hop_ip   = fields_q.next_hop_ip;
  assign resp_next_hop_port = fields_q.next_hop_port;
  assign resp_next_hop_qp   = fields_q.next_hop_qp;
  assign resp_next_hop_mac  = fields_q.next_hop_mac;

endmodule

`default_nettype wire

// File: tb/tb_dest_route_lookup.sv
// ============================================================================
// Module      : tb_dest_route_lookup
// Description : Directed vector bench for dest_route_lookup.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dest_route_lookup;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] init_data = '0;
  logic [5:0]   init_addr = '0;
  logic         init_valid = 1'b0, init_done = 1'b0, init_error = 1'b0;
  logic         req_valid = 1'b0, req_ready;
  logic [31:0]  req_dst_ip = '0;
  logic         resp_valid, resp_ready = 1'b1;
  logic         resp_hit, resp_broadcast, resp_direct_host;
  logic [15:0]  resp_out_port, resp_out_qp, resp_next_hop_port, resp_next_hop_qp;
  logic [31:0]  resp_next_hop_ip;
  logic [47:0]  resp_next_hop_mac;
  logic         table_ready, table_error;
  logic [6:0]   entry_count;

  always #5 clk = ~clk;

  dest_route_lookup #(.MAX_ENTRIES(64)) dut (
    .clk(clk), .rst(rst), .init_data(init_data), .init_addr(init_addr),
    .init_valid(init_valid), .init_done(init_done), .init_error(init_error),
    .req_valid(req_valid), .req_ready(req_ready), .req_dst_ip(req_dst_ip),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_broadcast(resp_broadcast), .resp_direct_host(resp_direct_host),
    .resp_out_port(resp_out_port), .resp_out_qp(resp_out_qp),
    .resp_next_hop_ip(resp_next_hop_ip), .resp_next_hop_port(resp_next_hop_port),
    .resp_next_hop_qp(resp_next_hop_qp), .resp_next_hop_mac(resp_next_hop_mac),
    .table_ready(table_ready), .table_error(table_error), .entry_count(entry_count)
  );

  typedef struct {
    logic [31:0] ip;
    logic        hit;
    int          lat;
    logic        bc;
    logic        dh;
    logic [15:0] op;
    logic [15:0] oq;
    logic [31:0] nip;
    logic [15:0] np;
    logic [15:0] nq;
    logic [47:0] mac;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic        cap_hit, cap_bc, cap_dh;
  logic [15:0] cap_op, cap_oq, cap_np, cap_nq;
  logic [31:0] cap_nip;
  logic [47:0] cap_mac;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [31:0] dst, input logic v, input logic dh,
                                      input logic bc, input logic [15:0] op, input logic [15:0] oq,
                                      input logic [31:0] nip, input logic [15:0] np,
                                      input logic [15:0] nq, input logic [47:0] mac);
    logic [255:0] e;
    e = '0;
    e[31:0]    = dst;
    e[32]      = v;
    e[33]      = dh;
    e[34]      = bc;
    e[79:64]   = op;
    e[95:80]   = oq;
    e[127:96]  = nip;
    e[143:128] = np;
    e[159:144] = nq;
    e[207:192] = mac[47:32];
    e[175:160] = mac[31:16];
    e[191:176] = mac[15:0];
    return e;
  endfunction

  // All tasks start and end on a falling edge.
  task automatic wr(input logic [5:0] a, input logic [255:0] d);
    init_valid = 1'b1;
    init_addr  = a;
    init_data  = d;
    @(negedge clk);
    init_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    init_valid = 1'b0; init_done = 1'b0; init_error = 1'b0; req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] ip, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL req_ready_wait: got 0 expected 1 within 50 cycles");
    end
    req_valid  = 1'b1;
    req_dst_ip = ip;
    @(negedge clk);
    req_valid = 1'b0;
    chk("req_ready_after_accept", req_ready, 0);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    cap_hit = resp_hit; cap_bc = resp_broadcast; cap_dh = resp_direct_host;
    cap_op = resp_out_port; cap_oq = resp_out_qp; cap_nip = resp_next_hop_ip;
    cap_np = resp_next_hop_port; cap_nq = resp_next_hop_qp; cap_mac = resp_next_hop_mac;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    lookup(v.ip, lat);
    chk($sformatf("lat_%h", v.ip), 64'(lat), 64'(v.lat));
    chk($sformatf("hit_%h", v.ip), cap_hit, v.hit);
    chk($sformatf("flags_%h", v.ip), {cap_bc, cap_dh}, {v.bc, v.dh});
    chk($sformatf("port_qp_%h", v.ip), {cap_op, cap_oq}, {v.op, v.oq});
    chk($sformatf("nh_ip_%h", v.ip), cap_nip, v.nip);
    chk($sformatf("nh_port_qp_%h", v.ip), {cap_np, cap_nq}, {v.np, v.nq});
    chk($sformatf("nh_mac_%h", v.ip), cap_mac, v.mac);
    @(negedge clk);
    chk("resp_one_cycle", resp_valid, 0);
    chk("req_ready_after_resp", req_ready, 1);
  endtask

  vec_t va[4];
  vec_t vb[3];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    va[0] = '{32'h0A000002, 1'b1, 3, 1'b1, 1'b0, 16'h0022, 16'h0A02, 32'hC0A80002, 16'h1222, 16'h2222, 48'h0200_0000_0002};
    va[1] = '{32'h0A000001, 1'b1, 2, 1'b0, 1'b1, 16'h0011, 16'h0A01, 32'hC0A80001, 16'h1111, 16'h2111, 48'h0200_0000_0001};
    va[2] = '{32'h0A000003, 1'b1, 4, 1'b0, 1'b0, 16'h0033, 16'h0A03, 32'hC0A80003, 16'h1333, 16'h2333, 48'h0200_ABCD_0003};
    va[3] = '{32'h0A000009, 1'b0, 5, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 16'h0, 16'h0, 48'h0};
    vb[0] = '{32'h0A000005, 1'b1, 3, 1'b0, 1'b0, 16'h0005, 16'h0B05, 32'h0A0000FE, 16'h0050, 16'h0051, 48'hAABB_CCDD_EE05};
    vb[1] = '{32'h0A000007, 1'b0, 6, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 16'h0, 16'h0, 48'h0};
    vb[2] = '{32'h0A000008, 1'b1, 4, 1'b1, 1'b1, 16'h0008, 16'h0B08, 32'h0A000008, 16'h0080, 16'h0081, 48'h1122_3344_5508};

    @(negedge clk);
    do_reset();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_table_flags", {table_ready, table_error}, 2'b00);
    chk("rst_entry_count", entry_count, 0);
    chk("rst_resp_fields", {resp_hit, resp_out_port, resp_next_hop_ip, resp_next_hop_mac}, 0);

    // Table A; the last write shares its cycle with init_done.
    wr(6'd0, mk(32'h0A000001, 1, 1, 0, 16'h0011, 16'h0A01, 32'hC0A80001, 16'h1111, 16'h2111, 48'h0200_0000_0001));
    wr(6'd1, mk(32'h0A000002, 1, 0, 1, 16'h0022, 16'h0A02, 32'hC0A80002, 16'h1222, 16'h2222, 48'h0200_0000_0002));
    chk("load_not_ready", table_ready, 0);
    init_done = 1'b1;
    wr(6'd2, mk(32'h0A000003, 1, 0, 0, 16'h0033, 16'h0A03, 32'hC0A80003, 16'h1333, 16'h2333, 48'h0200_ABCD_0003));
    init_done = 1'b0;
    chk("a_table_ready", table_ready, 1);
    chk("a_entry_count", entry_count, 3);
    wr(6'd5, mk(32'h0A000009, 1, 0, 0, 16'h0099, 16'h0, 32'h0, 16'h0, 16'h0, 48'h0));
    chk("a_count_after_late_write", entry_count, 3);
    for (int i = 0; i < 4; i++) run_vec(va[i]);

    begin : backpressure
      int lat;
      resp_ready = 1'b0;
      lookup(32'h0A000001, lat);
      chk("bp_lat", 64'(lat), 2);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        chk("bp_resp_valid", resp_valid, 1);
        chk("bp_out_port", resp_out_port, 16'h0011);
        chk("bp_req_ready", req_ready, 0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_req_ready", req_ready, 1);
      chk("bp_release_resp_valid", resp_valid, 0);
    end

    // Table B: invalid entry, overwrite, out-of-order writes, duplicate key.
    do_reset();
    wr(6'd1, mk(32'h0A000005, 1, 0, 0, 16'hDEAD, 16'hDEAD, 32'hDEADDEAD, 16'h0, 16'h0, 48'h0));
    wr(6'd0, mk(32'h0A000007, 0, 1, 1, 16'h0077, 16'h0B07, 32'h0A000077, 16'h0070, 16'h0071, 48'hFFFF_FFFF_FF07));
    wr(6'd3, mk(32'h0A000005, 1, 0, 0, 16'h0009, 16'h0B09, 32'h0A000009, 16'h0090, 16'h0091, 48'hAABB_CCDD_EE09));
    wr(6'd1, mk(32'h0A000005, 1, 0, 0, 16'h0005, 16'h0B05, 32'h0A0000FE, 16'h0050, 16'h0051, 48'hAABB_CCDD_EE05));
    wr(6'd2, mk(32'h0A000008, 1, 1, 1, 16'h0008, 16'h0B08, 32'h0A000008, 16'h0080, 16'h0081, 48'h1122_3344_5508));
    init_done = 1'b1;
    @(negedge clk);
    init_done = 1'b0;
    chk("b_entry_count", entry_count, 4);
    for (int i = 0; i < 3; i++) run_vec(vb[i]);

    // Reset in the middle of a scan drops the response.
    req_valid = 1'b1; req_dst_ip = 32'h0A000007;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("midrst_resp_valid", resp_valid, 0);
      @(negedge clk);
    end
    chk("midrst_state", {table_ready, req_ready, entry_count}, 0);

    // Error load; init_error outranks init_done.
    do_reset();
    wr(6'd0, mk(32'h0A000001, 1, 0, 0, 16'h1, 16'h1, 32'h1, 16'h1, 16'h1, 48'h1));
    init_error = 1'b1; init_done = 1'b1;
    @(negedge clk);
    init_error = 1'b0; init_done = 1'b0;
    chk("err_table_error", table_error, 1);
    chk("err_table_ready", table_ready, 0);
    chk("err_entry_count", entry_count, 1);
    req_valid = 1'b1; req_dst_ip = 32'h0A000001;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("err_req_ready", req_ready, 0);
      chk("err_resp_valid", resp_valid, 0);
    end
    req_valid = 1'b0;
    do_reset();
    chk("err_rst_count", entry_count, 0);
    chk("err_rst_error", table_error, 0);

    // Empty table.
    init_done = 1'b1;
    @(negedge clk);
    init_done = 1'b0;
    chk("empty_ready", table_ready, 1);
    begin : empty_lookup
      int lat;
      lookup(32'h0A000001, lat);
      chk("empty_lat", 64'(lat), 2);
      chk("empty_hit", cap_hit, 0);
      chk("empty_fields", {cap_op, cap_nip, cap_mac}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
